wash_cycle_controller: RTL and testbench

Top-level sequencer for one wash program: fill, wash, drain, spin. Drives the fill/drain valves and drum motor, and owns the flow-monitor interface. It selects the monitor's fill/drain mode, re-arms the monitor on every fill or drain phase, and latches a fault when the monitor flags stalled flow or the door opens mid-program. Sits between the user panel (start/abort/door) and the valve/motor/monitor datapath.

---
 rtl/wash_cycle_controller.sv | 164 ++++++++++++++++
 tb/tb_wash_cycle_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle_controller.sv
// Wash program sequencer: fill, wash, drain, spin. Owns the valves, drum motor
// and the flow-monitor handshake, and latches a fault on stalled flow or an open door.
module wash_cycle_controller #(
    parameter int unsigned FULL_LEVEL  = 800,
    parameter int unsigned EMPTY_LEVEL = 50,
    parameter int unsigned WASH_CYCLES = 20,
    parameter int unsigned SPIN_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       door_closed,
    input  logic [9:0] water_level_sensor,
    input  logic       flow_error,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       motor_on,
    output logic       monitor_mode,
    output logic       monitor_reset,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_WASH    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_SPIN    = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAULT   = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_t;

    localparam logic [9:0]  FULL_L    = FULL_LEVEL[9:0];
    localparam logic [9:0]  EMPTY_L   = EMPTY_LEVEL[9:0];
    localparam logic [15:0] WASH_LAST = 16'(WASH_CYCLES - 1);
    localparam logic [15:0] SPIN_LAST = 16'(SPIN_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic        r_entry;
    logic        w_entry_next;
    logic        w_flow_stall;
    logic        w_full;
    logic        w_empty;

    logic r_fill_valve, r_drain_valve, r_motor_on, r_monitor_mode;
    logic r_busy, r_done, r_fault;
    logic w_fill_valve, w_drain_valve, w_motor_on, w_monitor_mode;
    logic w_busy, w_done, w_fault;

    // The monitor's flag is clearing during the re-arm pulse, so it is ignored then.
    assign w_flow_stall = flow_error && !r_entry;
    assign w_full       = (water_level_sensor >= FULL_L);
    assign w_empty      = (water_level_sensor <= EMPTY_L);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && door_closed) w_next = ST_FILL;
            end
            ST_FILL: begin
                if (!door_closed || w_flow_stall) w_next = ST_FAULT;
                else if (abort)                   w_next = ST_DRAIN;
                else if (w_full)                  w_next = ST_WASH;
            end
            ST_WASH: begin
                if (!door_closed)              w_next = ST_FAULT;
                else if (abort)                w_next = ST_DRAIN;
                else if (r_cnt == WASH_LAST)   w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!door_closed || w_flow_stall) w_next = ST_FAULT;
                else if (w_empty)                 w_next = ST_SPIN;
            end
            ST_SPIN: begin
                if (!door_closed)              w_next = ST_FAULT;
                else if (r_cnt == SPIN_LAST)   w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Counter only advances inside the timed phases and restarts on any transition.
    always_comb begin
        w_cnt_next = 16'd0;
        if (w_next == r_state && (r_state == ST_WASH || r_state == ST_SPIN))
            w_cnt_next = r_cnt + 16'd1;
    end

    assign w_entry_next = (w_next != r_state) && (w_next == ST_FILL || w_next == ST_DRAIN);

    // Outputs are decoded from the next state so the registered copies track r_state.
    always_comb begin
        w_fill_valve   = 1'b0;
        w_drain_valve  = 1'b0;
        w_motor_on     = 1'b0;
        w_monitor_mode = 1'b0;
        w_busy         = (w_next != ST_IDLE);
        w_done         = 1'b0;
        w_fault        = 1'b0;
        case (w_next)
            ST_FILL: begin
                w_fill_valve   = 1'b1;
                w_monitor_mode = 1'b1;
            end
            ST_WASH:  w_motor_on    = 1'b1;
            ST_DRAIN: w_drain_valve = 1'b1;
            ST_SPIN: begin
                w_drain_valve = 1'b1;
                w_motor_on    = 1'b1;
            end
            ST_DONE:  w_done  = 1'b1;
            ST_FAULT: w_fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 16'd0;
            r_entry        <= 1'b0;
            r_fill_valve   <= 1'b0;
            r_drain_valve  <= 1'b0;
            r_motor_on     <= 1'b0;
            r_monitor_mode <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt_next;
            r_entry        <= w_entry_next;
            r_fill_valve   <= w_fill_valve;
            r_drain_valve  <= w_drain_valve;
            r_motor_on     <= w_motor_on;
            r_monitor_mode <= w_monitor_mode;
            r_busy         <= w_busy;
            r_done         <= w_done;
            r_fault        <= w_fault;
        end
    end

    assign fill_valve    = r_fill_valve;
    assign drain_valve   = r_drain_valve;
    assign motor_on      = r_motor_on;
    assign monitor_mode  = r_monitor_mode;
    assign monitor_reset = r_entry;
    assign busy          = r_busy;
    assign done          = r_done;
    assign fault         = r_fault;
    assign state         = r_state;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Bench for wash_cycle_controller: scripted vector table, a hand-written
// flow-error sequence, then randomized traffic against a phase/timer model.
module tb_wash_cycle_controller;

    localparam int FULL_N  = 800;
    localparam int EMPTY_N = 50;
    localparam int WASH_N  = 4;
    localparam int SPIN_N  = 3;

    // Output vector order: {fill, drain, motor, mode, mreset, busy, done, fault}
    localparam logic [7:0] O_IDLE    = 8'b0000_0000;
    localparam logic [7:0] O_FILL_E  = 8'b1001_1100;
    localparam logic [7:0] O_FILL    = 8'b1001_0100;
    localparam logic [7:0] O_WASH    = 8'b0010_0100;
    localparam logic [7:0] O_DRAIN_E = 8'b0100_1100;
    localparam logic [7:0] O_DRAIN   = 8'b0100_0100;
    localparam logic [7:0] O_SPIN    = 8'b0110_0100;
    localparam logic [7:0] O_DONE    = 8'b0000_0110;
    localparam logic [7:0] O_FAULT   = 8'b0000_0101;

    localparam int P_IDLE = 0, P_FILL = 1, P_WASH = 2, P_DRAIN = 3;
    localparam int P_SPIN = 4, P_DONE = 5, P_FAULT = 6;

    logic       clk = 1'b0;
    logic       reset, start, abort, door_closed, flow_error;
    logic [9:0] water_level_sensor;
    logic       fill_valve, drain_valve, motor_on, monitor_mode, monitor_reset;
    logic       busy, done, fault;
    logic [2:0] state;
    logic [7:0] outs;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       rst, st, ab, dr;
        logic [9:0] lvl;
        logic       fe;
        logic [2:0] est;
        logic [7:0] eout;
    } vec_t;

    vec_t tbl[$];

    int m_phase = P_IDLE;
    int m_left  = 0;
    bit m_fresh = 1'b0;

    wash_cycle_controller #(
        .FULL_LEVEL (FULL_N),
        .EMPTY_LEVEL(EMPTY_N),
        .WASH_CYCLES(WASH_N),
        .SPIN_CYCLES(SPIN_N)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .door_closed       (door_closed),
        .water_level_sensor(water_level_sensor),
        .flow_error        (flow_error),
        .fill_valve        (fill_valve),
        .drain_valve       (drain_valve),
        .motor_on          (motor_on),
        .monitor_mode      (monitor_mode),
        .monitor_reset     (monitor_reset),
        .busy              (busy),
        .done              (done),
        .fault             (fault),
        .state             (state)
    );

    always #5 clk = ~clk;

    assign outs = {fill_valve, drain_valve, motor_on, monitor_mode,
                   monitor_reset, busy, done, fault};

    task automatic add(input logic r, s, a, d, input int lv, input logic fe,
                       input logic [2:0] est, input logic [7:0] eo);
        vec_t v;
        v.rst = r; v.st = s; v.ab = a; v.dr = d;
        v.lvl = 10'(lv); v.fe = fe; v.est = est; v.eout = eo;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, s, a, d, input logic [9:0] lv, input logic fe);
        @(negedge clk);
        reset = r; start = s; abort = a; door_closed = d;
        water_level_sensor = lv; flow_error = fe;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] est, input logic [7:0] eo);
        n_vec++;
        if (state !== est || outs !== eo) begin
            n_miss++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, outs, est, eo);
        end
    endtask

    task automatic model_step(input bit r, s, a, d, input int lv, input bit fe);
        int np;
        if (r) begin
            m_phase = P_IDLE; m_fresh = 1'b0; m_left = 0;
            return;
        end
        np = m_phase;
        case (m_phase)
            P_IDLE:  if (s && d) np = P_FILL;
            P_FILL: begin
                if (!d || (fe && !m_fresh)) np = P_FAULT;
                else if (a)                 np = P_DRAIN;
                else if (lv >= FULL_N)      np = P_WASH;
            end
            P_WASH: begin
                if (!d)                     np = P_FAULT;
                else if (a || m_left == 1)  np = P_DRAIN;
            end
            P_DRAIN: begin
                if (!d || (fe && !m_fresh)) np = P_FAULT;
                else if (lv <= EMPTY_N)     np = P_SPIN;
            end
            P_SPIN: begin
                if (!d)                     np = P_FAULT;
                else if (m_left == 1)       np = P_DONE;
            end
            P_DONE:  np = P_IDLE;
            default: ;
        endcase
        if (np != m_phase) begin
            m_phase = np;
            m_fresh = (np == P_FILL || np == P_DRAIN);
            m_left  = (np == P_WASH) ? WASH_N : (np == P_SPIN) ? SPIN_N : 0;
        end else begin
            m_fresh = 1'b0;
            if (m_left > 0) m_left--;
        end
    endtask

    function automatic logic [7:0] model_outs();
        logic [7:0] o;
        o[7] = (m_phase == P_FILL);
        o[6] = (m_phase == P_DRAIN) || (m_phase == P_SPIN);
        o[5] = (m_phase == P_WASH) || (m_phase == P_SPIN);
        o[4] = (m_phase == P_FILL);
        o[3] = m_fresh;
        o[2] = (m_phase != P_IDLE);
        o[1] = (m_phase == P_DONE);
        o[0] = (m_phase == P_FAULT);
        return o;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; door_closed = 1'b1;
        flow_error = 1'b0; water_level_sensor = 10'd0;

        // Normal program
        add(1,0,0,1,0,0, 0, O_IDLE);
        add(0,1,0,1,0,0, 1, O_FILL_E);
        add(0,0,0,1,400,0, 1, O_FILL);
        for (int i = 0; i < WASH_N; i++) add(0,0,0,1,820,0, 2, O_WASH);
        add(0,0,0,1,820,0, 3, O_DRAIN_E);
        add(0,0,0,1,400,0, 3, O_DRAIN);
        for (int i = 0; i < SPIN_N; i++) add(0,0,0,1,30,0, 4, O_SPIN);
        add(0,0,0,1,30,0, 5, O_DONE);
        add(0,0,0,1,30,0, 0, O_IDLE);
        // Flow stall in the third FILL cycle, then start/abort ignored in FAULT
        add(0,1,0,1,0,0, 1, O_FILL_E);
        add(0,0,0,1,0,0, 1, O_FILL);
        add(0,0,0,1,0,0, 1, O_FILL);
        add(0,0,0,1,0,1, 6, O_FAULT);
        add(0,1,0,1,0,0, 6, O_FAULT);
        add(0,0,1,1,0,0, 6, O_FAULT);
        add(1,0,0,1,0,0, 0, O_IDLE);
        // Exact level thresholds and flow_error masked in DRAIN re-arm cycle
        add(0,1,0,1,0,0, 1, O_FILL_E);
        add(0,0,0,1,799,0, 1, O_FILL);
        add(0,0,0,1,800,0, 2, O_WASH);
        for (int i = 1; i < WASH_N; i++) add(0,0,0,1,800,0, 2, O_WASH);
        add(0,0,0,1,800,0, 3, O_DRAIN_E);
        add(0,0,0,1,400,1, 3, O_DRAIN);
        add(0,0,0,1,51,0, 3, O_DRAIN);
        add(0,0,0,1,50,0, 4, O_SPIN);
        for (int i = 1; i < SPIN_N; i++) add(0,0,0,1,50,0, 4, O_SPIN);
        add(0,0,0,1,50,0, 5, O_DONE);
        add(0,0,0,1,50,0, 0, O_IDLE);
        // Abort in WASH at count 1; abort held through DRAIN and SPIN
        add(0,1,0,1,0,0, 1, O_FILL_E);
        add(0,0,0,1,820,0, 2, O_WASH);
        add(0,0,0,1,820,0, 2, O_WASH);
        add(0,0,1,1,820,0, 3, O_DRAIN_E);
        add(0,0,1,1,400,0, 3, O_DRAIN);
        for (int i = 0; i < SPIN_N; i++) add(0,0,1,1,30,0, 4, O_SPIN);
        add(0,0,0,1,30,0, 5, O_DONE);
        add(0,0,0,1,30,0, 0, O_IDLE);
        // Abort in FILL
        add(0,1,0,1,0,0, 1, O_FILL_E);
        add(0,0,1,1,0,0, 3, O_DRAIN_E);
        for (int i = 0; i < SPIN_N; i++) add(0,0,0,1,30,0, 4, O_SPIN);
        add(0,0,0,1,30,0, 5, O_DONE);
        add(0,0,0,1,30,0, 0, O_IDLE);
        // Door: start ignored while open; door opens in SPIN
        add(0,1,0,0,0,0, 0, O_IDLE);
        add(0,1,0,1,0,0, 1, O_FILL_E);
        for (int i = 0; i < WASH_N; i++) add(0,0,0,1,820,0, 2, O_WASH);
        add(0,0,0,1,820,0, 3, O_DRAIN_E);
        add(0,0,0,1,30,0, 4, O_SPIN);
        add(0,0,0,0,30,0, 6, O_FAULT);
        add(1,0,0,1,30,0, 0, O_IDLE);
        // Door open and level full in the same FILL cycle
        add(0,1,0,1,0,0, 1, O_FILL_E);
        add(0,0,0,0,820,0, 6, O_FAULT);
        add(1,0,0,1,0,0, 0, O_IDLE);
        // Reset in WASH
        add(0,1,0,1,0,0, 1, O_FILL_E);
        add(0,0,0,1,820,0, 2, O_WASH);
        add(0,0,0,1,820,0, 2, O_WASH);
        add(1,0,0,1,820,0, 0, O_IDLE);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].st, tbl[i].ab, tbl[i].dr, tbl[i].lvl, tbl[i].fe);
            check($sformatf("table[%0d]", i), tbl[i].est, tbl[i].eout);
        end

        // Hand sequence: flow_error held from FILL entry is masked one cycle only
        drive(1,0,0,1,10'd0,0);
        check("seq_reset", 3'd0, O_IDLE);
        drive(0,1,0,1,10'd0,1);
        check("seq_fill_entry", 3'd1, O_FILL_E);
        drive(0,0,0,1,10'd0,1);
        check("seq_masked", 3'd1, O_FILL);
        drive(0,0,0,1,10'd0,1);
        check("seq_stall", 3'd6, O_FAULT);
        drive(1,0,0,1,10'd0,0);
        check("seq_exit", 3'd0, O_IDLE);

        // Randomized traffic against the reference model
        model_step(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            logic r, s, a, d, fe;
            logic [9:0] lv;
            int sel;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 11) == 0);
            d  = ($urandom_range(0, 49) != 0);
            fe = ($urandom_range(0, 24) == 0);
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: lv = 10'd800;
                1: lv = 10'd50;
                2: lv = 10'd799;
                3: lv = 10'd51;
                4, 5, 6: lv = 10'($urandom_range(0, 1023));
                default: lv = water_level_sensor;
            endcase
            drive(r, s, a, d, lv, fe);
            model_step(r, s, a, d, int'(lv), fe);
            check($sformatf("random[%0d]", c), 3'(m_phase), model_outs());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
